// File: rtl/axi_gen_pkg.sv
// Shared types and constants for the strided AXI4 read generator.
// Holds the run-state enum, err_code bit positions and the data-width helper.
package axi_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gen_state_e;

    localparam int ERR_ID_BIT    = 0;
    localparam int ERR_LAST_BIT  = 1;
    localparam int ERR_UNEXP_BIT = 2;
    localparam int ERR_BITS      = 3;

    function automatic int data_width(input int log_block_data_bytes);
        return 8 << log_block_data_bytes;
    endfunction

endpackage

// File: rtl/axi_gen_rd_checker.sv
// R-channel sink: counts accepted beats, folds data into an XOR checksum and
// flags id, last-placement and unexpected-beat errors (sticky until clear).
module axi_gen_rd_checker
    import axi_gen_pkg::*;
#(
    parameter int TID_WIDTH       = 4,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
    input  logic [TID_WIDTH-1:0]       cfg_id,
    input  logic                       none_outstanding,
    input  logic                       r_valid,
    output logic                       r_ready,
    input  logic [DATA_WIDTH-1:0]      r_data,
    input  logic                       r_last,
    input  logic [TID_WIDTH-1:0]       r_id,
    output logic                       burst_close,
    output logic [CNT_WIDTH-1:0]       beat_cnt,
    output logic [DATA_WIDTH-1:0]      checksum,
    output logic [ERR_BITS-1:0]        err_code
);

    logic                       r_ready_q;
    logic [BURST_LEN_WIDTH-1:0] beat_in_burst_q;
    logic                       r_fire;

    assign r_ready     = r_ready_q;
    assign r_fire      = r_valid && r_ready_q;
    // A last beat only retires a burst when one is actually in flight.
    assign burst_close = r_fire && !none_outstanding && r_last;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready_q       <= 1'b0;
            beat_in_burst_q <= '0;
            beat_cnt        <= '0;
            checksum        <= '0;
            err_code        <= '0;
        end else begin
            r_ready_q <= 1'b1;
            if (clear) begin
                beat_in_burst_q <= '0;
                beat_cnt        <= '0;
                checksum        <= '0;
                err_code        <= '0;
            end else if (r_fire) begin
                if (none_outstanding) begin
                    // Stray beat: flagged only, counters and checksum untouched.
                    err_code[ERR_UNEXP_BIT] <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    checksum <= checksum ^ r_data;
                    if (r_id != cfg_id)
                        err_code[ERR_ID_BIT] <= 1'b1;
                    if (r_last != (beat_in_burst_q == cfg_len))
                        err_code[ERR_LAST_BIT] <= 1'b1;
                    beat_in_burst_q <= r_last ? '0 : beat_in_burst_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi_stride_read_gen.sv
// AXI4 read initiator issuing cfg_count strided AR bursts with a bounded number
// in flight; the R channel is sunk and checked by axi_gen_rd_checker.
module axi_stride_read_gen
    import axi_gen_pkg::*;
#(
    parameter int ADDR_BITS            = 64,
    parameter int TID_WIDTH            = 4,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 3,
    parameter int LOG_MAX_OUTSTANDING  = 2,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [ADDR_BITS-1:0]                         cfg_base,
    input  logic [ADDR_BITS-1:0]                         cfg_stride,
    input  logic [CNT_WIDTH-1:0]                         cfg_count,
    input  logic [BURST_LEN_WIDTH-1:0]                   cfg_len,
    input  logic [TID_WIDTH-1:0]                         cfg_id,
    output logic                                         m_ar_valid,
    input  logic                                         m_ar_ready,
    output logic [ADDR_BITS-1:0]                         m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]                   m_ar_len,
    output logic [TID_WIDTH-1:0]                         m_ar_id,
    input  logic                                         m_r_valid,
    output logic                                         m_r_ready,
    input  logic [data_width(LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
    input  logic                                         m_r_last,
    input  logic [TID_WIDTH-1:0]                         m_r_id,
    output logic                                         busy,
    output logic                                         done,
    output logic [CNT_WIDTH-1:0]                         beat_cnt,
    output logic [data_width(LOG_BLOCK_DATA_BYTES)-1:0]  checksum,
    output logic [ERR_BITS-1:0]                          err_code
);

    localparam int DATA_WIDTH = data_width(LOG_BLOCK_DATA_BYTES);
    localparam int OUT_W      = LOG_MAX_OUTSTANDING + 1;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(1 << LOG_MAX_OUTSTANDING);

    gen_state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]       stride_q;
    logic [CNT_WIDTH-1:0]       count_q;
    logic [CNT_WIDTH-1:0]       issued_q, issued_nxt;
    logic [OUT_W-1:0]           outstanding_q, outstanding_nxt;
    logic                       ar_valid_q;
    logic [ADDR_BITS-1:0]       ar_addr_q;
    logic [BURST_LEN_WIDTH-1:0] ar_len_q;
    logic [TID_WIDTH-1:0]       ar_id_q;
    logic                       start_accept;
    logic                       ar_fire;
    logic                       burst_close;
    logic                       can_issue;

    assign start_accept = start && (state_q == IDLE || state_q == DONE);
    assign ar_fire      = ar_valid_q && m_ar_ready;
    assign issued_nxt   = issued_q + CNT_WIDTH'(ar_fire);

    assign m_ar_valid = ar_valid_q;
    assign m_ar_addr  = ar_addr_q;
    assign m_ar_len   = ar_len_q;
    assign m_ar_id    = ar_id_q;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        outstanding_nxt = outstanding_q;
        if (ar_fire && !burst_close)
            outstanding_nxt = outstanding_q + OUT_W'(1);
        else if (!ar_fire && burst_close)
            outstanding_nxt = outstanding_q - OUT_W'(1);
    end

    // Decided on post-handshake counts so a new burst can follow on the next cycle.
    assign can_issue = (state_q == RUN) && (issued_nxt < count_q) && (outstanding_nxt < MAX_OUT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (cfg_count == '0) ? DONE : RUN;
            RUN:        if (issued_q == count_q) state_d = DRAIN;
            DRAIN:      if (outstanding_q == '0) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            stride_q      <= '0;
            count_q       <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            ar_valid_q    <= 1'b0;
            ar_addr_q     <= '0;
            ar_len_q      <= '0;
            ar_id_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_accept) begin
                stride_q      <= cfg_stride;
                count_q       <= cfg_count;
                ar_len_q      <= cfg_len;
                ar_id_q       <= cfg_id;
                ar_addr_q     <= cfg_base;
                issued_q      <= '0;
                outstanding_q <= '0;
                ar_valid_q    <= 1'b0;
            end else begin
                issued_q      <= issued_nxt;
                outstanding_q <= outstanding_nxt;
                if (ar_fire)
                    ar_addr_q <= ar_addr_q + stride_q;
                // A raised valid is held until the handshake completes.
                if (!ar_valid_q || m_ar_ready)
                    ar_valid_q <= can_issue;
            end
        end
    end

    axi_gen_rd_checker #(
        .TID_WIDTH       (TID_WIDTH),
        .BURST_LEN_WIDTH (BURST_LEN_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_rd_checker (
        .clk              (clk),
        .rst              (rst),
        .clear            (start_accept),
        .cfg_len          (ar_len_q),
        .cfg_id           (ar_id_q),
        .none_outstanding (outstanding_q == '0),
        .r_valid          (m_r_valid),
        .r_ready          (m_r_ready),
        .r_data           (m_r_data),
        .r_last           (m_r_last),
        .r_id             (m_r_id),
        .burst_close      (burst_close),
        .beat_cnt         (beat_cnt),
        .checksum         (checksum),
        .err_code         (err_code)
    );

endmodule

// File: doc/axi_stride_read_gen.md
Name: axi_stride_read_gen

Overview:
- AXI4 read-channel initiator that plays the accelerator side of the prefetcher's slave port.
- Issues a programmable sequence of strided AR bursts, sinks and checks R beats, and reports counters, a data checksum and sticky protocol errors.
- Used as the active read master in prefetcher integration benches and as a synthesizable traffic source on FPGA bring-up. Its m_* ports connect to prefetcherTop s_ar_* / s_r_*.

Parameters:
- ADDR_BITS, 64, AR address width.
- TID_WIDTH, 4, AXI ID width.
- BURST_LEN_WIDTH, 8, AR len width (beats-1 encoding).
- LOG_BLOCK_DATA_BYTES, 3, log2 of data-bus bytes; DATA_WIDTH = 8<<LOG_BLOCK_DATA_BYTES.
- LOG_MAX_OUTSTANDING, 2, log2 of the maximum number of in-flight bursts.
- CNT_WIDTH, 16, width of the request and beat counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse: sample config and begin a run
- cfg_base  in  ADDR_BITS  first burst address
- cfg_stride  in  ADDR_BITS  address increment per burst (two's complement, wraps mod 2^ADDR_BITS)
- cfg_count  in  CNT_WIDTH  number of bursts to issue
- cfg_len  in  BURST_LEN_WIDTH  AR len for every burst
- cfg_id  in  TID_WIDTH  ARID for every burst
- m_ar_valid  out  1  AR valid
- m_ar_ready  in  1  AR ready
- m_ar_addr  out  ADDR_BITS  AR address
- m_ar_len  out  BURST_LEN_WIDTH  AR len
- m_ar_id  out  TID_WIDTH  AR id
- m_r_valid  in  1  R valid
- m_r_ready  out  1  R ready
- m_r_data  in  DATA_WIDTH  R data
- m_r_last  in  1  R last
- m_r_id  in  TID_WIDTH  R id
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- beat_cnt  out  CNT_WIDTH  accepted R beats in the current run
- checksum  out  DATA_WIDTH  XOR of all accepted R data beats
- err_code  out  3  sticky errors: [0] id mismatch, [1] last misplaced or missing, [2] unexpected beat

Behaviour:
- Reset values: all outputs 0 and state IDLE, except m_r_ready, which is 1 from the first clk edge after rst deasserts.
- FSM transitions:
  - IDLE: on start, latch cfg_*, clear beat_cnt, checksum, err_code and the issued/outstanding/beat-in-burst counters; go to RUN. If cfg_count==0, go to DONE instead.
  - RUN: when issued==cfg_count, go to DRAIN on that edge.
  - DRAIN: when outstanding==0, go to DONE.
  - DONE: start behaves exactly as in IDLE. No other exit.
- AR issue:
  - m_ar_valid asserts when state==RUN, issued<cfg_count and outstanding<2^LOG_MAX_OUTSTANDING. Address/len/id are registered.
  - Once valid is high, valid/addr/len/id stay stable until m_ar_ready is sampled high (AXI rule). Valid never drops without a handshake, even if rst-free conditions change.
  - On handshake: issued+1, and next addr = addr + cfg_stride, truncated to ADDR_BITS (wrap allowed).
  - Back-to-back issue allowed: a new valid may appear the cycle after a handshake, so one burst per cycle at most.
- Outstanding counter:
  - +1 on AR handshake, -1 on an R handshake carrying last.
  - Simultaneous AR handshake and last beat: unchanged.
  - Width LOG_MAX_OUTSTANDING+1; it never exceeds the maximum.
- R acceptance:
  - m_r_ready is 1 in every state out of reset; beats are never back-pressured.
  - Each accepted beat: beat_cnt+1 (wraps), checksum ^= m_r_data, beat-in-burst+1.
  - m_r_id != latched cfg_id sets err_code[0].
  - m_r_last high when beat-in-burst != cfg_len, or low when it == cfg_len, sets err_code[1]. The burst is treated as closed at the m_r_last beat regardless.
  - A beat accepted while outstanding==0 (any state, including IDLE/DONE) sets err_code[2] and does not change outstanding or beat_cnt.
- Error bits are sticky until the next start.
- start while busy is ignored.
- rst mid-run aborts immediately to reset values. In-flight responses after reset release are flagged by err_code[2] only after a later start, because err_code is cleared at start.
- done is a level, not a pulse.

Decomposition:
- Package axi_gen_pkg: state enum (IDLE, RUN, DRAIN, DONE), err_code bit-index constants, and a helper function for DATA_WIDTH from LOG_BLOCK_DATA_BYTES.
- One natural sub-module, axi_gen_rd_checker: R-channel beat counting, last/id checking and checksum. The top module keeps the FSM and AR issue logic.

Test Plan:
- Against axi_ram preloaded with mem[i]=i, 64-bit data: base=0x100, stride=0x40, count=4, len=0 -> ARADDR 0x100, 0x140, 0x180, 0x1C0; beat_cnt=4; checksum=0x20^0x28^0x30^0x38; err_code=0; done=1.
- count=3, len=3, stride=0x20 -> 12 beats accepted; each burst's last is on its 4th beat; outstanding returns to 0; done=1; err_code=0.
- Responder holds m_ar_ready=0 for 5 cycles and R delayed -> m_ar_valid/addr stay stable for those 5 cycles; at most 4 ARs are accepted before the first R returns.
- Stub responder returns m_r_id=cfg_id+1, then a burst with last on beat 2 of len=3 -> err_code=3'b011, and the run still completes.
- Stray R beat injected in IDLE after a finished run, then start with count=0 -> err_code[2] is set before start, cleared at start; done=1 on the next cycle; no AR issued.
- rst pulsed during RUN with 2 bursts outstanding -> all outputs 0 in the same cycle (async), state IDLE; after release m_r_ready=1.
